// File: rtl/alu_op_sequencer.sv
// ALU op decoder and multi-cycle MUL/DIV sequencer.
// Define ALU_SEQ_DIV_EN to build in the restoring divider.
module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       opex,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [4:0]       alu_sel,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [4:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_q, rem_q, a_q, b_q;
    logic [WIDTH-1:0] mul_sum;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, err_q;
    logic             last;

    always_comb begin
        sel_d = {1'b0, opex[3:0]};
        if (ctrl[0] | ctrl[1])
            sel_d = 5'h1F;
        else if (ctrl[3])
            sel_d = 5'h00;
        else if (opcode[5:4] == 2'b10 || opcode[5:3] == 3'b110)
            sel_d = 5'h1F;
        else if (ctrl[2])
            sel_d = (opcode[4:1] == 4'b1000) ? 5'h1F : {1'b0, opcode[3:0]};
        else if (opex >= 6'h14 && opex <= 6'h19)
            sel_d = 5'h10;
        else if (opex < 6'h12)
            sel_d = opex[4:0];
    end

    assign mul_sum = b_q[0] ? res_q + a_q : res_q;
    assign last    = (cnt_q == CW'(1));

`ifdef ALU_SEQ_DIV_EN
    // Dividend shifts out of res_q as quotient bits shift in.
    logic [WIDTH:0] rem_sh, rem_sub;
    assign rem_sh  = {rem_q, res_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sel_q <= sel_d;
                        a_q   <= a;
                        b_q   <= b;
                        res_q <= '0;
                        rem_q <= '0;
                        err_q <= 1'b0;
                        cnt_q <= CW'(WIDTH);
                        if (sel_d == 5'h02) begin
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
                        end else if (sel_d == 5'h03) begin
                            if (b == '0) begin
                                res_q   <= '1;
                                rem_q   <= a;
                                err_q   <= 1'b1;
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                res_q   <= a;
                                state_q <= S_DIV;
                                busy_q  <= 1'b1;
                            end
`else
                        end else if (sel_d == 5'h03) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    res_q <= mul_sum;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    if (!rem_sub[WIDTH]) begin
                        rem_q <= rem_sub[WIDTH-1:0];
                        res_q <= {res_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[WIDTH-1:0];
                        res_q <= {res_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`else
                S_DIV: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_sel   = sel_q;
    assign result    = res_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
